insn_encoder_loader: RTL and testbench

Instruction encoder and sequential loader for the ECE550 single-cycle CPU. It accepts decoded operation descriptions (kind plus register/immediate fields) over a valid/ready handshake and packs each one into the 32-bit instruction word the CPU's control decode consumes. It writes the packed words into instruction memory at consecutive addresses, so a bench or boot path can program the CPU without a pre-assembled image.

---
 rtl/insn_encoder_loader.sv | 155 +++++++++++++++
 tb/tb_insn_encoder_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/insn_encoder_loader.sv
// Packs decoded operations into 32-bit CPU instruction words and writes them to
// consecutive instruction-memory addresses. Optional macro: ENCODER_IMM_CHECK_EN.
module insn_encoder_loader #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [1:0]    i_op_kind,
  input  logic [4:0]    i_rd,
  input  logic [4:0]    i_rs,
  input  logic [4:0]    i_rt,
  input  logic [4:0]    i_shamt,
  input  logic [4:0]    i_alu_op,
  input  logic [31:0]   i_imm,
  output logic          o_imem_we,
  output logic [AW-1:0] o_imem_addr,
  output logic [31:0]   o_imem_data,
  output logic [AW:0]   o_count,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  localparam logic [1:0] KIND_R    = 2'd0;
  localparam logic [1:0] KIND_ADDI = 2'd1;
  localparam logic [1:0] KIND_LW   = 2'd2;
  localparam logic [1:0] KIND_SW   = 2'd3;

  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [1:0]    r_state;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;

  logic          w_in_ready;
  logic          w_xfer;
  logic          w_reject;
  logic          w_write;
  logic [31:0]   w_word;
  logic [AW:0]   w_count_next;

  function automatic logic [31:0] encode(
    input logic [1:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  shamt,
    input logic [4:0]  alu_op,
    input logic [16:0] imm
  );
    logic [31:0] word;
    word = 32'd0;
    case (kind)
      KIND_R:    word = {5'b00000, rd, rs, rt, shamt, alu_op, 2'b00};
      KIND_ADDI: word = {5'b00101, rd, rs, imm};
      KIND_LW:   word = {5'b01000, rd, rs, imm};
      KIND_SW:   word = {5'b00111, rd, rs, imm};
      default:   word = 32'd0;
    endcase
    return word;
  endfunction

  // An immediate fits when bits [31:16] are all copies of bit 16.
  function automatic logic imm_fits(input logic [31:0] imm);
    return (&imm[31:16]) | ~(|imm[31:16]);
  endfunction

  assign w_in_ready   = (r_state == LOAD) & ~i_start;
  assign w_xfer       = i_in_valid & w_in_ready;
  assign w_word       = encode(i_op_kind, i_rd, i_rs, i_rt, i_shamt, i_alu_op, i_imm[16:0]);
  assign w_count_next = r_count + (AW + 1)'(1);
  assign w_write      = w_xfer & ~w_reject;

`ifdef ENCODER_IMM_CHECK_EN
  logic r_err;

  assign w_reject = (i_op_kind != KIND_R) & ~imm_fits(i_imm);

  // Sticky out-of-range flag, cleared only by start or reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (i_start) begin
      r_err <= 1'b0;
    end else if (w_xfer & w_reject) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_imm;

  assign w_reject     = 1'b0;
  assign w_unused_imm = ^{i_imm[31:17], imm_fits(i_imm)};
  assign o_err        = 1'b0;
`endif

  // Load sequencing, write pointer and registered memory-write port.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (i_start) begin
        r_state <= LOAD;
        r_wptr  <= '0;
        r_count <= '0;
        r_addr  <= '0;
      end else if (w_xfer) begin
        r_count <= w_count_next;
        if (w_count_next == COUNT_FULL) begin
          r_state <= FULL;
        end else begin
          r_state <= r_state;
        end
        if (w_write) begin
          r_we   <= 1'b1;
          r_addr <= r_wptr;
          r_data <= w_word;
          r_wptr <= r_wptr + AW'(1);
        end else begin
          r_wptr <= r_wptr;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_imem_we   = r_we;
  assign o_imem_addr = r_addr;
  assign o_imem_data = r_data;
  assign o_count     = r_count;
  assign o_done      = (r_state == FULL);

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Directed bench for insn_encoder_loader with a 4-word memory; expected words
// are hand-encoded from the instruction field layout.
module tb_insn_encoder_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op_kind;
  logic [4:0]    rd;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    shamt;
  logic [4:0]    alu_op;
  logic [31:0]   imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  int checks;
  int failures;

  insn_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clock     (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op_kind   (op_kind),
    .i_rd        (rd),
    .i_rs        (rs),
    .i_rt        (rt),
    .i_shamt     (shamt),
    .i_alu_op    (alu_op),
    .i_imm       (imm),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_data (imem_data),
    .o_count     (count),
    .o_done      (done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s,
                        input logic [4:0] t, input logic [31:0] im);
    op_kind = k; rd = d; rs = s; rt = t; shamt = 5'd0; alu_op = 5'd0; imm = im;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_op(2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #3;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", imem_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Single R-type transfer
    do_start();
    #1;
    chk("load_ready", 32'(in_ready), 32'd1);
    set_op(2'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("r_we", 32'(imem_we), 32'd1);
    chk("r_addr", 32'(imem_addr), 32'd0);
    chk("r_data", imem_data, 32'h00C2_2000);
    chk("r_count", 32'(count), 32'd1);
    tick();
    chk("r_we_pulse", 32'(imem_we), 32'd0);

    // addi then lw back-to-back
    do_start();
    chk("restart_count", 32'(count), 32'd0);
    set_op(2'd1, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    tick();
    chk("addi_we", 32'(imem_we), 32'd1);
    chk("addi_addr", 32'(imem_addr), 32'd0);
    chk("addi_data", imem_data, 32'h2840_0005);
    set_op(2'd2, 5'd2, 5'd1, 5'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    chk("lw_we", 32'(imem_we), 32'd1);
    chk("lw_addr", 32'(imem_addr), 32'd1);
    chk("lw_data", imem_data, 32'h4083_FFFF);
    tick();

    // start together with in_valid after two writes
    start = 1'b1;
    in_valid = 1'b1;
    set_op(2'd1, 5'd1, 5'd0, 5'd0, 32'd7);
    #1;
    chk("start_blocks_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    chk("start_no_write", 32'(imem_we), 32'd0);
    chk("start_count", 32'(count), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("post_start_we", 32'(imem_we), 32'd1);
    chk("post_start_addr", 32'(imem_addr), 32'd0);
    chk("post_start_data", imem_data, 32'h2840_0007);

    // Fill all four words, then a fifth transfer must be refused
    do_start();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(2'd1, 5'd0, 5'd0, 5'd0, 32'(i));
      tick();
      if (i < 4) begin
        chk("fill_we", 32'(imem_we), 32'd1);
        chk("fill_addr", 32'(imem_addr), 32'(i));
        chk("fill_data", imem_data, 32'h2800_0000 + 32'(i));
      end else begin
        chk("full_no_we", 32'(imem_we), 32'd0);
      end
      if (i >= 3) begin
        chk("full_done", 32'(done), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;

    // sw with an out-of-range immediate, then an in-range one
    do_start();
    chk("start_clears_done", 32'(done), 32'd0);
    set_op(2'd3, 5'd4, 5'd2, 5'd0, 32'd70000);
    in_valid = 1'b1;
    tick();
`ifdef ENCODER_IMM_CHECK_EN
    chk("bigimm_we", 32'(imem_we), 32'd0);
    chk("bigimm_err", 32'(err), 32'd1);
`else
    chk("bigimm_we", 32'(imem_we), 32'd1);
    chk("bigimm_data", imem_data, 32'h3905_1170);
    chk("bigimm_err", 32'(err), 32'd0);
`endif
    chk("bigimm_count", 32'(count), 32'd1);
    set_op(2'd3, 5'd4, 5'd2, 5'd0, 32'd4);
    tick();
    in_valid = 1'b0;
    chk("sw_we", 32'(imem_we), 32'd1);
    chk("sw_data", imem_data, 32'h3904_0004);
`ifdef ENCODER_IMM_CHECK_EN
    chk("sw_addr", 32'(imem_addr), 32'd0);
    chk("sw_err", 32'(err), 32'd1);
`else
    chk("sw_addr", 32'(imem_addr), 32'd1);
    chk("sw_err", 32'(err), 32'd0);
`endif
    chk("sw_count", 32'(count), 32'd2);

    // Reset during the cycle carrying a write
    do_start();
    set_op(2'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_data", imem_data, 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrst_we_held", 32'(imem_we), 32'd0);
    reset = 1'b0;
    tick();
    chk("after_rst_ready", 32'(in_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
